imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//  Shares the single read port of the 64-word combinational instruction memory between two requesters.
//  Requester F is the core fetch path; requester D is the debug/program-inspect port.
//  Sits between both requesters and imem: drives imem addr, registers imem readdata back to the winner.
//  Round-robin arbitration; D may lock the port for multi-word dumps, bounded by a fairness timeout.
// PARAMETERS
//  N        32  data width (bits), matches imem readdata
//  R        6   address width (64 word slots)
//  LOCK_MAX 8   max consecutive D grants while locked before F is forced a slot (>=1)
// PORTS
//  clk            in   1   clock, all state on posedge
//  reset          in   1   synchronous, active-high
//  f_req          in   1   F request; held high with f_addr stable until f_gnt
//  f_addr         in   R   F word address
//  f_gnt          out  1   F granted this cycle (combinational)
//  f_rvalid       out  1   F read data valid (1-cycle pulse)
//  f_rdata        out  N   F read data, held until next F response
//  d_req          in   1   D request; same hold rule as F
//  d_addr         in   R   D word address
//  d_hold         in   1   D lock request; sampled when d_gnt=1
//  d_gnt          out  1   D granted this cycle (combinational)
//  d_rvalid       out  1   D read data valid (1-cycle pulse)
//  d_rdata        out  N   D read data, held until next D response
//  imem_addr      out  R   to imem addr; granted addr, else last driven value
//  imem_readdata  in   N   from imem readdata (combinational on imem_addr)
//  locked         out  1   1 while FSM in LOCK
// BEHAVIOUR
//  Reset values
//   - All outputs 0 after reset; state=ARB, last=D (so F wins first tie), lock_cnt=0.
//  Grant and response timing
//   - At most one gnt per cycle; never gnt without matching req.
//   - Cycle N: gnt combinational; imem_addr = winner addr in same cycle.
//   - Posedge ending N: imem_readdata -> winner rdata; winner rvalid=1 for cycle N+1 only.
//   - Throughput 1 word/cycle; back-to-back grants to same requester allowed.
//  State ARB
//   - Only one req: grant it.
//   - Both req: grant requester != last; update last to the winner.
//   - D granted with d_hold=1: next state LOCK, lock_cnt=1.
//  State LOCK (locked=1)
//   - Only D is granted (when d_req=1); F is stalled, f_gnt=0.
//   - Each D grant increments lock_cnt, saturating at LOCK_MAX.
//   - d_hold=0 at any cycle: return to ARB the next cycle, lock_cnt=0, last=D.
//   - lock_cnt==LOCK_MAX and f_req=1: that cycle grant F instead of D (forced slot), then lock_cnt=0, stay LOCK.
//   - lock_cnt==LOCK_MAX and f_req=0: D continues to be granted.
//   - Idle cycles (no d_req) in LOCK do not change lock_cnt.
//  Hold and reset rules
//   - No req: imem_addr holds previous value, no rvalid next cycle.
//   - rdata registers update only on own response; other requester's rdata unaffected.
//   - Reset mid-transfer: pending rvalid suppressed (rvalid=0 the cycle after reset); lock released.
//   - Addresses are R bits, no range check; wrap is implicit (addr 63 then 0 is legal).
// TESTING
//  1 Reset, F only, f_addr=0,1,2 back-to-back -> f_gnt each cycle; f_rvalid next cycles with imem words 0,1,2.
//  2 F and D both req, f_addr=3, d_addr=5, held 4 cycles -> grants F,D,F,D.
//    f_rdata=mem[3], d_rdata=mem[5]; never both gnt in one cycle.
//  3 D lock with d_hold=1, d_addr stepping 10..19, F req continuous, LOCK_MAX=8 -> 8 D grants.
//    Then 1 F grant, then D resumes; locked=1 throughout.
//  4 In LOCK, drop d_hold -> locked=0 next cycle; with both req, F wins next arbitration.
//  5 Assert reset the cycle after a D grant -> d_rvalid=0, all outputs 0, locked=0.
//    First post-reset tie goes to F.
//  6 Idle gap and wrap, F addr 63 then no req 2 cycles then addr 0 -> imem_addr holds 63 while idle.
//    Then rdata=mem[63], mem[0]; no spurious rvalid.

Source files
------------

// File: rtl/imem_arbiter.sv
// Shares the single imem read port between fetch (F) and debug (D) requesters.
// Round-robin arbitration with a D lock mode bounded by a fairness timeout.
module imem_arbiter #(
  parameter int unsigned N        = 32,
  parameter int unsigned R        = 6,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         f_req,
  input  logic [R-1:0] f_addr,
  output logic         f_gnt,
  output logic         f_rvalid,
  output logic [N-1:0] f_rdata,
  input  logic         d_req,
  input  logic [R-1:0] d_addr,
  input  logic         d_hold,
  output logic         d_gnt,
  output logic         d_rvalid,
  output logic [N-1:0] d_rdata,
  output logic [R-1:0] imem_addr,
  input  logic [N-1:0] imem_readdata,
  output logic         locked
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  localparam logic ST_ARB  = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  logic          state_q, state_d;
  logic          last_d_q, last_d_d;   // 1: D won the most recent tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic [R-1:0]  addr_q;
  logic          f_win, d_win;
  logic          f_rvalid_q, d_rvalid_q;
  logic [N-1:0]  f_rdata_q, d_rdata_q;

  // Grant selection and next-state logic
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    f_win    = 1'b0;
    d_win    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_ARB: begin
          if (f_req && d_req) begin
            f_win    = last_d_q;
            d_win    = ~last_d_q;
            last_d_d = ~last_d_q;
          end else begin
            f_win = f_req;
            d_win = d_req;
          end
          if (d_win && d_hold) begin
            state_d = ST_LOCK;
            cnt_d   = CW'(1);
          end
        end
        default: begin
          // Fairness slot: F pre-empts D once the lock budget is spent
          if ((cnt_q == CW'(LOCK_MAX)) && f_req) begin
            f_win = 1'b1;
            cnt_d = '0;
          end else if (d_req) begin
            d_win = 1'b1;
            if (cnt_q < CW'(LOCK_MAX)) cnt_d = cnt_q + CW'(1);
          end
          if (!d_hold) begin
            state_d  = ST_ARB;
            cnt_d    = '0;
            last_d_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign f_gnt     = f_win;
  assign d_gnt     = d_win;
  assign imem_addr = f_win ? f_addr : (d_win ? d_addr : addr_q);
  assign f_rvalid  = f_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign locked    = (state_q == ST_LOCK);

  // State, held address and per-requester response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARB;
      last_d_q   <= 1'b1;
      cnt_q      <= '0;
      addr_q     <= '0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      cnt_q      <= cnt_d;
      addr_q     <= imem_addr;
      f_rvalid_q <= f_win;
      d_rvalid_q <= d_win;
      if (f_win) f_rdata_q <= imem_readdata;
      if (d_win) d_rdata_q <= imem_readdata;
    end
  end

endmodule
